// File: rtl/hist_drain.sv
// hist_drain: read-out engine for the histogram RAM.
// On start it stalls the increment pipeline, waits for in-flight updates to
// retire, then reads every bin in ascending order and streams (bin, count)
// beats over a valid/ready interface through a small output FIFO.
// Optional feature macro: HIST_DRAIN_CLEAR_EN (zero each bin as it is read).
module hist_drain #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hist_idle,
  output logic              hist_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_rdaddr,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_wraddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_bin,
  output logic [DATA_W-1:0] out_count,
  output logic              out_last
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + RD_LAT + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_QUIESCE = 2'd1;
  localparam logic [1:0] S_READ    = 2'd2;
  localparam logic [1:0] S_FLUSH   = 2'd3;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic              hold_d;
  logic [ADDR_W:0]   rd_ptr;
  logic [RD_LAT-1:0] pipe_valid;
  logic [ADDR_W-1:0] pipe_addr [RD_LAT];
  logic [ADDR_W-1:0] fifo_bin  [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_cnt  [FIFO_DEPTH];
  logic [PW-1:0]     wr_idx;
  logic [PW-1:0]     rd_idx;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     inflight;
  logic              issue;
  logic              push;
  logic              pop;
  logic              drained;

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (idx == PW'(FIFO_DEPTH - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Count reads still travelling through the RAM latency pipe.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(pipe_valid[i]);
    end
  end

  // A read is only issued when its result is guaranteed a FIFO slot.
  assign issue   = (state == S_READ) && !rd_ptr[ADDR_W] &&
                   ((inflight + fifo_count) < CW'(FIFO_DEPTH));
  assign push    = pipe_valid[RD_LAT-1];
  assign out_valid = (fifo_count != '0);
  assign pop     = out_valid && out_ready;
  assign drained = (fifo_count == '0) && (inflight == '0);

  // Next-state selection; hist_idle is trusted only once hold has been seen for a full cycle.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (start) state_nx = S_QUIESCE;
      S_QUIESCE: if (hold_d && hist_idle) state_nx = S_READ;
      S_READ:    if (rd_ptr[ADDR_W]) state_nx = S_FLUSH;
      S_FLUSH:   if (drained) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // State register, hold history and read pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      hold_d <= 1'b0;
      rd_ptr <= '0;
    end else begin
      state  <= state_nx;
      hold_d <= hist_hold;
      if (state == S_IDLE && start) begin
        rd_ptr <= '0;
      end else if (issue) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Valid bits of the read-latency pipe; cleared so a reset abandons every read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_valid <= '0;
    end else begin
      pipe_valid[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
      end
    end
  end

  // Bin addresses travelling alongside the valid bits.
  always_ff @(posedge clk) begin
    pipe_addr[0] <= rd_ptr[ADDR_W-1:0];
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_addr[i] <= pipe_addr[i-1];
    end
  end

  // Output FIFO: push returned data with its bin, pop on handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_idx     <= '0;
      rd_idx     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_bin[wr_idx] <= pipe_addr[RD_LAT-1];
        fifo_cnt[wr_idx] <= ram_q;
        wr_idx           <= next_idx(wr_idx);
      end
      if (pop) begin
        rd_idx <= next_idx(rd_idx);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign hist_hold  = (state != S_IDLE);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FLUSH) && drained;
  assign ram_rdaddr = issue ? rd_ptr[ADDR_W-1:0] : '0;
  assign ram_wdata  = '0;

  assign out_bin   = out_valid ? fifo_bin[rd_idx] : '0;
  assign out_count = out_valid ? fifo_cnt[rd_idx] : '0;
  assign out_last  = out_valid && (fifo_bin[rd_idx] == '1);

`ifdef HIST_DRAIN_CLEAR_EN
  assign ram_wren   = pipe_valid[RD_LAT-1];
  assign ram_wraddr = pipe_valid[RD_LAT-1] ? pipe_addr[RD_LAT-1] : '0;
`else
  assign ram_wren   = 1'b0;
  assign ram_wraddr = '0;
`endif

endmodule

// File: doc/hist_drain.md
Name: hist_drain

Overview:
- Read-out engine for the 32-bin histogram RAM that the increment pipeline fills; the increment pipeline writes the bins and this block reads them.
- On `start`, it freezes the increment pipeline and waits for in-flight updates to retire.
- It then reads every bin in ascending order and streams (bin, count) beats over a valid/ready interface.
- Sits beside the increment pipeline; a top-level mux gives this block both RAM ports while `hist_hold`=1.

Parameters:
- ADDR_W, 5: bin address width; 2^ADDR_W bins.
- DATA_W, 32: bin count width.
- RD_LAT, 2: RAM read latency in cycles, from rdaddress to valid q.
- FIFO_DEPTH, 4: output buffer depth; must be ≥ RD_LAT+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle request to drain all bins.
- hist_idle  in  1  increment pipeline has no enabled op in any stage.
- hist_hold  out  1  stall request to the increment pipeline; also selects this block onto the RAM ports.
- busy  out  1  drain in progress.
- done  out  1  one-cycle pulse after the final beat is accepted.
- ram_rdaddr  out  ADDR_W  RAM read address.
- ram_q  in  DATA_W  RAM read data, valid RD_LAT cycles after ram_rdaddr.
- ram_wraddr  out  ADDR_W  RAM write address (used by the clear option).
- ram_wdata  out  DATA_W  RAM write data; always 0.
- ram_wren  out  1  RAM write enable.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts the beat.
- out_bin  out  ADDR_W  bin index of the beat.
- out_count  out  DATA_W  bin count.
- out_last  out  1  beat is bin 2^ADDR_W-1.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State = IDLE; FIFO emptied; outstanding-read pipe cleared.
  - All outputs 0, including hist_hold, busy, done, out_valid and ram_wren.
  - Reset mid-drain abandons the drain silently; no done pulse; no write occurs on the following cycle.
- FSM states: IDLE, QUIESCE, READ, FLUSH.
  - IDLE → QUIESCE on start=1. hist_hold=1 and busy=1 from the next cycle.
  - QUIESCE → READ on the first cycle with hist_idle=1. hist_idle is sampled only when hist_hold was already 1 in the previous cycle.
  - READ: issue a read at rd_ptr when `inflight + fifo_count < FIFO_DEPTH`, then increment rd_ptr. rd_ptr is ADDR_W+1 bits.
  - READ → FLUSH when rd_ptr reaches 2^ADDR_W.
  - FLUSH → IDLE when the FIFO is empty, no reads are in flight, and the last beat has been accepted. In that cycle done=1, while busy and hist_hold are still 1; both drop on the next cycle.
- start while busy=1 is ignored.
- Read pipeline:
  - A RD_LAT-deep shift register carries {valid, addr} alongside each read.
  - When it emerges, ram_q is pushed into the FIFO together with the delayed addr.
  - The credit rule guarantees the FIFO never overflows, so returned data is never dropped.
- Output handshake:
  - Beat transfers when out_valid && out_ready.
  - out_valid = FIFO not empty; out_* come straight from the FIFO head.
  - While out_valid=1 and out_ready=0, out_* hold stable.
  - Full throughput: one beat per cycle when out_ready stays 1.
- Ordering and coverage:
  - Beats come out in strictly increasing bin order, 0 through 2^ADDR_W-1.
  - Each bin is read exactly once per drain.
  - out_last=1 only on bin 2^ADDR_W-1.
- Simultaneous events: a FIFO push and pop in the same cycle keep fifo_count unchanged.
- When idle: ram_rdaddr = 0 and ram_wren = 0.

Optional Feature:
- Macro: HIST_DRAIN_CLEAR_EN.
- Defined:
  - In the cycle each read result emerges from the latency pipe, assert ram_wren=1 with ram_wraddr = that bin and ram_wdata = 0.
  - The next histogram therefore starts from zero.
  - No hazard exists because each bin is read once, before its own clear.
- Undefined: ram_wren is tied 0 and the bins keep their counts.

Test Plan:
- Preload bin i = 100+i; start; out_ready=1 → 32 beats, bin 0..31 with counts 100..131 on consecutive cycles; out_last on bin 31; done exactly once.
- Same preload; out_ready toggles 1,0,0,1… → identical beat sequence; out_* stable while stalled; no lost or duplicated bins.
- start while hist_idle=0 for 5 cycles → hist_hold=1, no ram_rdaddr issue until hist_idle=1, then normal drain.
- rst_n=0 after bin 10 is accepted → all outputs 0 next cycle; a new start drains from bin 0 again.
- HIST_DRAIN_CLEAR_EN defined: drain twice → first pass counts 100..131, second pass all 0. Undefined: second pass repeats 100..131.
- start pulsed again mid-drain, and out_ready=0 for 20 cycles at bin 3 → second start ignored; at most FIFO_DEPTH reads outstanding; order preserved.
